// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder: FSM state encoding, default
// operand width and a helper that sizes the bit counter.
package serial_adder_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Operand width used when the instantiating block does not override it
  localparam int DEFAULT_WIDTH = 8;

  // Bit-counter width: clog2(width), never narrower than one bit so that a
  // single-bit adder still has a legal counter register.
  function automatic int cnt_width(input int width);
    if (width <= 1) begin
      return 1;
    end
    return $clog2(width);
  endfunction

endpackage

// File: rtl/serial_adder_full_adder_cell.sv
// Single-bit full adder assembled from two half-adder stages. The first stage
// adds the operand bits, the second folds in the incoming carry, and the two
// stage carries are ORed (they can never both be set).
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic ha0_sum;
  logic ha0_carry;
  logic ha1_carry;

  // First half adder: operand bits
  assign ha0_sum   = a ^ b;
  assign ha0_carry = a & b;

  // Second half adder: partial sum plus incoming carry
  assign s         = ha0_sum ^ cin;
  assign ha1_carry = ha0_sum & cin;

  // Carry out is set when either stage generated a carry
  assign cout      = ha0_carry | ha1_carry;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder. Operands are captured on an accepted start, then
// added LSB-first one bit per clock through a single full-adder cell whose
// carry is held in a flip-flop between cycles. The sum is assembled by
// shifting each result bit in at the MSB end, so after WIDTH cycles the
// register holds the complete sum and a one-cycle done pulse is raised.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int               CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic             s_bit;
  logic             c_bit;
  logic [WIDTH-1:0] sum_shift;

  // One full-adder cell serves every bit position over successive cycles
  full_adder_cell u_fa (
    .a    (sa[0]),
    .b    (sb[0]),
    .cin  (carry),
    .s    (s_bit),
    .cout (c_bit)
  );

  // Next sum value: new bit enters at the MSB, older bits move toward the LSB.
  // A one-bit adder has nothing to shift, so the new bit is the whole sum.
  generate
    if (WIDTH == 1) begin : g_sum_one
      assign sum_shift = s_bit;
    end else begin : g_sum_multi
      assign sum_shift = {s_bit, sum[WIDTH-1:1]};
    end
  endgenerate

  // FSM, operand shift registers, carry flop, bit counter and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      sa    <= '0;
      sb    <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          // Operands are captured only here; a/b are ignored at all other times
          if (start) begin
            sa    <= a;
            sb    <= b;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            state <= ST_RUN;
          end
        end

        ST_RUN: begin
          sum   <= sum_shift;
          sa    <= sa >> 1;
          sb    <= sb >> 1;
          carry <= c_bit;
          cnt   <= cnt + CNT_ONE;
          // The MSB's carry is the overflow of the whole addition
          if (cnt == LAST_BIT) begin
            cout  <= c_bit;
            state <= ST_DONE;
          end
        end

        ST_DONE: begin
          // Single-cycle result announcement; start is not queued
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Status flags decoded from registered state, so they cannot glitch
  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder. Expected results come from plain
// integer addition and the documented WIDTH-cycle latency.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  logic         start1 = 1'b0;
  logic [0:0]   a1     = '0;
  logic [0:0]   b1     = '0;
  logic         busy1;
  logic         done1;
  logic [0:0]   sum1;
  logic         cout1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start1),
    .a     (a1),
    .b     (b1),
    .busy  (busy1),
    .done  (done1),
    .sum   (sum1),
    .cout  (cout1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One addition on the WIDTH=8 instance, checked against x+y and latency W
  task automatic run_add(input string name, input logic [W-1:0] x,
                         input logic [W-1:0] y, input bit scramble);
    logic [W:0] expv;
    int n;
    int busy_cnt;
    expv = {1'b0, x} + {1'b0, y};
    a = x;
    b = y;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    busy_cnt = 0;
    while (done !== 1'b1 && n < 4 * W + 10) begin
      if (busy === 1'b1) busy_cnt++;
      if (scramble) begin
        a = W'($urandom);
        b = W'($urandom);
      end
      tick();
      n++;
    end
    checks++;
    if (n !== W) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles, expected %0d", name, n, W);
    end
    checks++;
    if (busy_cnt !== W || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy: got %0d busy cycles (busy=%b at done), expected %0d (busy=0)",
               name, busy_cnt, busy, W);
    end
    checks++;
    if ({cout, sum} !== expv) begin
      errors++;
      $display("FAIL %s result: got %0d, expected %0d (a=%0d b=%0d)", name, {cout, sum}, expv, x, y);
    end
    tick();
    checks++;
    if (done !== 1'b0 || {cout, sum} !== expv) begin
      errors++;
      $display("FAIL %s hold: got done=%b result=%0d, expected done=0 result=%0d",
               name, done, {cout, sum}, expv);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({busy, done, cout, sum} !== '0) begin
      errors++;
      $display("FAIL reset_w8: got busy=%b done=%b cout=%b sum=%0d, expected all 0", busy, done, cout, sum);
    end
    checks++;
    if ({busy1, done1, cout1, sum1} !== 4'b0) begin
      errors++;
      $display("FAIL reset_w1: got busy=%b done=%b cout=%b sum=%0d, expected all 0", busy1, done1, cout1, sum1);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    run_add("add_3_5", 8'd3, 8'd5, 1'b0);
  endtask

  task automatic test_overflow();
    run_add("add_255_1", 8'd255, 8'd1, 1'b0);
    run_add("add_170_85", 8'd170, 8'd85, 1'b0);
    run_add("add_255_255", 8'd255, 8'd255, 1'b0);
  endtask

  task automatic test_ignore_start();
    int extra_done;
    a = 8'd100;
    b = 8'd27;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    a = 8'd1;
    b = 8'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4 * W && done !== 1'b1; i++) tick();
    checks++;
    if (done !== 1'b1 || {cout, sum} !== 9'd127) begin
      errors++;
      $display("FAIL ignore_start: got done=%b result=%0d, expected done=1 result=127", done, {cout, sum});
    end
    extra_done = 0;
    for (int i = 0; i < 3 * W; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) extra_done++;
    end
    checks++;
    if (extra_done !== 0 || sum !== 8'd127) begin
      errors++;
      $display("FAIL ignore_start_after: got %0d active cycles sum=%0d, expected 0 and sum=127", extra_done, sum);
    end
  endtask

  task automatic test_mid_reset();
    int stray;
    a = 8'd200;
    b = 8'd100;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if ({busy, done, cout, sum} !== '0) begin
      errors++;
      $display("FAIL mid_reset: got busy=%b done=%b cout=%b sum=%0d, expected all 0", busy, done, cout, sum);
    end
    stray = 0;
    for (int i = 0; i < 2 * W; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) stray++;
    end
    checks++;
    if (stray !== 0) begin
      errors++;
      $display("FAIL mid_reset_quiet: got %0d active cycles, expected 0", stray);
    end
    run_add("after_reset_7_9", 8'd7, 8'd9, 1'b0);
  endtask

  task automatic test_back_to_back();
    int done_t[$];
    int bad_res;
    a = 8'd10;
    b = 8'd20;
    start = 1'b1;
    bad_res = 0;
    for (int t = 1; t <= 5 * (W + 2); t++) begin
      tick();
      if (done === 1'b1) begin
        done_t.push_back(t);
        if ({cout, sum} !== 9'd30) bad_res++;
      end
    end
    start = 1'b0;
    checks++;
    if (done_t.size() !== 5 || bad_res !== 0) begin
      errors++;
      $display("FAIL back_to_back_count: got %0d dones (%0d bad results), expected 5 with result 30",
               done_t.size(), bad_res);
    end
    checks++;
    if (done_t.size() < 1 || done_t[0] !== W + 1) begin
      errors++;
      $display("FAIL back_to_back_first: got first done at %0d, expected %0d",
               (done_t.size() > 0) ? done_t[0] : -1, W + 1);
    end
    for (int i = 1; i < done_t.size(); i++) begin
      checks++;
      if (done_t[i] - done_t[i-1] !== W + 2) begin
        errors++;
        $display("FAIL back_to_back_period: got %0d, expected %0d", done_t[i] - done_t[i-1], W + 2);
      end
    end
    // Let any run started on the final edges drain before the next test
    for (int i = 0; i < 2 * W + 4; i++) tick();
  endtask

  task automatic test_width1();
    logic [1:0] expv;
    for (int x = 0; x < 2; x++) begin
      for (int y = 0; y < 2; y++) begin
        expv = 2'(x + y);
        a1 = 1'(x);
        b1 = 1'(y);
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        checks++;
        if (busy1 !== 1'b1 || done1 !== 1'b0) begin
          errors++;
          $display("FAIL w1_run %0d+%0d: got busy=%b done=%b, expected busy=1 done=0", x, y, busy1, done1);
        end
        tick();
        checks++;
        if (done1 !== 1'b1 || {cout1, sum1} !== expv) begin
          errors++;
          $display("FAIL w1_done %0d+%0d: got done=%b result=%0d, expected done=1 result=%0d",
                   x, y, done1, {cout1, sum1}, expv);
        end
        tick();
        checks++;
        if (done1 !== 1'b0 || busy1 !== 1'b0) begin
          errors++;
          $display("FAIL w1_idle %0d+%0d: got busy=%b done=%b, expected 0 0", x, y, busy1, done1);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1000; i++) begin
      run_add("random", W'($urandom), W'($urandom), 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_ignore_start();
    test_mid_reset();
    test_back_to_back();
    test_width1();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
